// File: rtl/sprite_line_fetcher.sv
// Prefetches each player's sprite row for the next display line from the shared
// sprite ROM into double-buffered line buffers that the pixel mux reads by column.
module sprite_line_fetcher #(
    parameter int SPR_W  = 128,
    parameter int ADDR_W = 16,
    parameter int PIX_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              line_start,
    input  logic [9:0]        next_line,
    input  logic [9:0]        p1_y,
    input  logic [9:0]        p2_y,
    input  logic [1:0]        p1_frame,
    input  logic [1:0]        p2_frame,
    input  logic              p2_flip,
    output logic              rom_en,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [PIX_W-1:0]  rom_data,
    input  logic [6:0]        p1_rd_x,
    input  logic [6:0]        p2_rd_x,
    output logic [PIX_W-1:0]  p1_rd_pixel,
    output logic [PIX_W-1:0]  p2_rd_pixel,
    output logic              p1_line_vld,
    output logic              p2_line_vld,
    output logic              busy,
    output logic              overrun
);

    localparam int COL_W = 7;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(SPR_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH_P1,
        FETCH_P2,
        DRAIN
    } state_t;

    state_t state_reg, state_next;
    logic [COL_W-1:0] col_reg, col_next;

    logic [9:0]       py       [2];
    logic [1:0]       frame_in [2];
    logic [6:0]       rd_x     [2];
    logic [PIX_W-1:0] rd_pixel [2];
    logic [1:0]       in_now;
    logic [6:0]       row_now  [2];

    logic [1:0] frame_reg [2];
    logic [6:0] row_reg   [2];
    logic [1:0] in_reg;
    logic       flip_reg;
    logic [1:0] fill_vld_reg;
    logic [1:0] line_vld_reg;
    logic       bank_sel_reg;
    logic       overrun_reg;

    logic             wr_en_reg;
    logic             wr_player_reg;
    logic [COL_W-1:0] wr_col_reg;

    logic             issue_p2;
    logic [COL_W-1:0] rom_col;

    assign py[0]       = p1_y;
    assign py[1]       = p2_y;
    assign frame_in[0] = p1_frame;
    assign frame_in[1] = p2_frame;
    assign rd_x[0]     = p1_rd_x;
    assign rd_x[1]     = p2_rd_x;

    // Range check in 11 bits so a sprite near the bottom of the 10-bit space never wraps.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_range
            logic [10:0] line_ext;
            logic [10:0] py_ext;
            logic [10:0] diff;
            assign line_ext    = {1'b0, next_line};
            assign py_ext      = {1'b0, py[gi]};
            assign diff        = line_ext - py_ext;
            assign in_now[gi]  = (line_ext >= py_ext) && (line_ext < py_ext + 11'(SPR_W));
            assign row_now[gi] = diff[6:0];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            col_reg   <= '0;
        end else begin
            state_reg <= state_next;
            col_reg   <= col_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        col_next   = col_reg;
        rom_en     = 1'b0;
        rom_addr   = '0;
        issue_p2   = 1'b0;
        rom_col    = col_reg;
        case (state_reg)
            IDLE: ;
            FETCH_P1: begin
                if (!in_reg[0]) begin
                    state_next = FETCH_P2;
                end else begin
                    rom_en   = 1'b1;
                    rom_addr = {frame_reg[0], row_reg[0], col_reg};
                    col_next = col_reg + 1'b1;
                    if (col_reg == COL_LAST) state_next = FETCH_P2;
                end
            end
            FETCH_P2: begin
                if (!in_reg[1]) begin
                    state_next = DRAIN;
                end else begin
                    rom_en   = 1'b1;
                    issue_p2 = 1'b1;
                    rom_col  = flip_reg ? (COL_LAST - col_reg) : col_reg;
                    rom_addr = {frame_reg[1], row_reg[1], rom_col};
                    col_next = col_reg + 1'b1;
                    if (col_reg == COL_LAST) state_next = DRAIN;
                end
            end
            DRAIN:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // A new line always restarts the schedule, aborting whatever was running.
        if (line_start) begin
            state_next = FETCH_P1;
            col_next   = '0;
        end
    end

    assign busy = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_reg     <= 1'b0;
            wr_player_reg <= 1'b0;
            wr_col_reg    <= '0;
            overrun_reg   <= 1'b0;
            bank_sel_reg  <= 1'b0;
            fill_vld_reg  <= '0;
            line_vld_reg  <= '0;
            in_reg        <= '0;
            flip_reg      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                frame_reg[i] <= '0;
                row_reg[i]   <= '0;
            end
        end else begin
            // A read issued on the line_start cycle belongs to the aborted line.
            wr_en_reg     <= rom_en && !line_start;
            wr_player_reg <= issue_p2;
            wr_col_reg    <= col_reg;
            overrun_reg   <= line_start && busy;
            if (line_start) begin
                bank_sel_reg <= ~bank_sel_reg;
                line_vld_reg <= busy ? 2'b00 : fill_vld_reg;
                fill_vld_reg <= '0;
                in_reg       <= in_now;
                flip_reg     <= p2_flip;
                for (int i = 0; i < 2; i++) begin
                    frame_reg[i] <= frame_in[i];
                    row_reg[i]   <= row_now[i];
                end
            end else if (wr_en_reg && (wr_col_reg == COL_LAST)) begin
                fill_vld_reg[wr_player_reg] <= 1'b1;
            end
        end
    end

    // Per-player line buffer: two banks of SPR_W pixels, indexed {bank, screen column}.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_buf
            logic [PIX_W-1:0] buf_mem [0:2*SPR_W-1];
            always_ff @(posedge clk) begin
                if (wr_en_reg && (wr_player_reg == 1'(gi))) begin
                    buf_mem[{~bank_sel_reg, wr_col_reg}] <= rom_data;
                end
            end
            assign rd_pixel[gi] = buf_mem[{bank_sel_reg, rd_x[gi]}];
        end
    endgenerate

    assign p1_rd_pixel = rd_pixel[0];
    assign p2_rd_pixel = rd_pixel[1];
    assign p1_line_vld = line_vld_reg[0];
    assign p2_line_vld = line_vld_reg[1];
    assign overrun     = overrun_reg;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Bench for sprite_line_fetcher: a line-level schedule model predicts every ROM read,
// busy/overrun/valid flags and display pixels; directed cases pin the model with literals.
module tb_sprite_line_fetcher;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        line_start = 1'b0;
    logic [9:0]  next_line = '0;
    logic [9:0]  p1_y = '0;
    logic [9:0]  p2_y = '0;
    logic [1:0]  p1_frame = '0;
    logic [1:0]  p2_frame = '0;
    logic        p2_flip = 1'b0;
    logic        rom_en;
    logic [15:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic [6:0]  p1_rd_x = '0;
    logic [6:0]  p2_rd_x = '0;
    logic [11:0] p1_rd_pixel;
    logic [11:0] p2_rd_pixel;
    logic        p1_line_vld;
    logic        p2_line_vld;
    logic        busy;
    logic        overrun;

    sprite_line_fetcher dut (
        .clk(clk), .rst(rst), .line_start(line_start), .next_line(next_line),
        .p1_y(p1_y), .p2_y(p2_y), .p1_frame(p1_frame), .p2_frame(p2_frame),
        .p2_flip(p2_flip), .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data),
        .p1_rd_x(p1_rd_x), .p2_rd_x(p2_rd_x), .p1_rd_pixel(p1_rd_pixel),
        .p2_rd_pixel(p2_rd_pixel), .p1_line_vld(p1_line_vld), .p2_line_vld(p2_line_vld),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] rom_f(input logic [15:0] a);
        logic [11:0] lo;
        lo = a[11:0] * 12'd37;
        return lo ^ {a[15:12], a[15:12], a[15:12]};
    endfunction

    always @(posedge clk) if (rom_en) rom_data <= rom_f(rom_addr);

    int n_total = 0;
    int n_pass  = 0;

    // Schedule model: s_* is the line being fetched, d_* the line on display.
    bit         m_active = 0;
    int         m_t = 0;
    bit         m_ov = 0;
    logic [1:0] s_in = '0;
    logic [6:0] s_row [2];
    logic [1:0] s_f   [2];
    logic       s_flip = 1'b0;
    logic [1:0] d_vld = '0;
    logic [6:0] d_row [2];
    logic [1:0] d_f   [2];
    logic       d_flip = 1'b0;

    logic [15:0] rd_log [$];
    int ov_cnt = 0;
    int mark = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic cycle_check();
        logic        exp_en;
        logic        exp_busy;
        logic [15:0] exp_addr;
        logic [6:0]  col7;
        int p1len, p2len, L, py;
        if (rst) begin
            m_active = 0; m_t = 0; m_ov = 0; d_vld = '0;
            check("rst_rom_en", 32'(rom_en), 32'd0);
            check("rst_rom_addr", 32'(rom_addr), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_overrun", 32'(overrun), 32'd0);
            check("rst_p1_vld", 32'(p1_line_vld), 32'd0);
            check("rst_p2_vld", 32'(p2_line_vld), 32'd0);
            return;
        end
        p1len    = s_in[0] ? 128 : 1;
        p2len    = s_in[1] ? 128 : 1;
        exp_en   = 1'b0;
        exp_addr = '0;
        exp_busy = m_active && (m_t <= p1len + p2len + 1);
        if (m_active && m_t >= 1 && m_t <= p1len && s_in[0]) begin
            col7 = 7'(m_t - 1);
            exp_en = 1'b1;
            exp_addr = {s_f[0], s_row[0], col7};
        end else if (m_active && m_t > p1len && m_t <= p1len + p2len && s_in[1]) begin
            col7 = 7'(m_t - p1len - 1);
            if (s_flip) col7 = 7'd127 - col7;
            exp_en = 1'b1;
            exp_addr = {s_f[1], s_row[1], col7};
        end
        check("rom_en", 32'(rom_en), 32'(exp_en));
        if (exp_en) check("rom_addr", 32'(rom_addr), 32'(exp_addr));
        check("busy", 32'(busy), 32'(exp_busy));
        check("overrun", 32'(overrun), 32'(m_ov && m_t == 1));
        check("p1_line_vld", 32'(p1_line_vld), 32'(d_vld[0]));
        check("p2_line_vld", 32'(p2_line_vld), 32'(d_vld[1]));
        if (d_vld[0]) begin
            col7 = p1_rd_x;
            check("p1_pixel", 32'(p1_rd_pixel), 32'(rom_f({d_f[0], d_row[0], col7})));
        end
        if (d_vld[1]) begin
            col7 = d_flip ? 7'd127 - p2_rd_x : p2_rd_x;
            check("p2_pixel", 32'(p2_rd_pixel), 32'(rom_f({d_f[1], d_row[1], col7})));
        end
        if (rom_en) rd_log.push_back(rom_addr);
        if (overrun) ov_cnt++;
        if (line_start) begin
            d_vld[0] = m_active && s_in[0] && !exp_busy;
            d_vld[1] = m_active && s_in[1] && !exp_busy;
            d_row = s_row; d_f = s_f; d_flip = s_flip;
            L = int'(next_line);
            for (int i = 0; i < 2; i++) begin
                py = (i == 0) ? int'(p1_y) : int'(p2_y);
                s_in[i]  = (L >= py) && (L < py + 128);
                s_row[i] = 7'(L - py);
            end
            s_f[0] = p1_frame; s_f[1] = p2_frame; s_flip = p2_flip;
            m_ov = exp_busy; m_active = 1; m_t = 1;
        end else if (m_active && m_t < 1000) begin
            m_t++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cycle_check();
        @(posedge clk);
        #1;
        p1_rd_x = 7'($urandom_range(0, 127));
        p2_rd_x = 7'($urandom_range(0, 127));
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic start_line(input int L, input int y1, input int y2,
                              input int f1, input int f2, input int fl);
        next_line = 10'(L); p1_y = 10'(y1); p2_y = 10'(y2);
        p1_frame = 2'(f1); p2_frame = 2'(f2); p2_flip = 1'(fl);
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
        mark = rd_log.size();
    endtask

    int b_line [4]  = '{199, 200, 327, 328};
    int b_reads [4] = '{0, 128, 128, 0};
    int b_first [4] = '{0, 'h8000, 'hBF80, 0};

    initial begin
        int oc, L, y1, y2, gap;
        run(3);
        rst = 1'b0;
        run(20);

        // p1 only, frame 2, row 10
        start_line(110, 100, 300, 2, 0, 0);
        run(280);
        check("t2_reads", 32'(rd_log.size() - mark), 32'd128);
        check("t2_first", 32'(rd_log[mark]), 32'h8500);
        check("t2_last", 32'(rd_log[mark + 127]), 32'h857F);
        start_line(600, 100, 300, 0, 0, 0);
        check("t2_p1_vld", 32'(p1_line_vld), 32'd1);
        check("t2_p2_vld", 32'(p2_line_vld), 32'd0);
        p1_rd_x = 7'd5;
        #1;
        check("t2_pix5", 32'(p1_rd_pixel), 32'(rom_f(16'h8505)));
        run(280);

        // both players, p2 mirrored
        start_line(300, 250, 300, 1, 3, 1);
        run(280);
        check("t3_reads", 32'(rd_log.size() - mark), 32'd256);
        check("t3_p1_first", 32'(rd_log[mark]), 32'h5900);
        check("t3_p2_first", 32'(rd_log[mark + 128]), 32'hC07F);
        start_line(600, 0, 0, 0, 0, 0);
        check("t3_p2_vld", 32'(p2_line_vld), 32'd1);
        p2_rd_x = 7'd0;
        #1;
        check("t3_p2_pix0", 32'(p2_rd_pixel), 32'(rom_f(16'hC07F)));
        run(280);

        // range boundaries around p1_y=200
        for (int i = 0; i < 4; i++) begin
            start_line(b_line[i], 200, 900, 2, 0, 0);
            run(280);
            check("t4_reads", 32'(rd_log.size() - mark), 32'(b_reads[i]));
            if (b_reads[i] != 0) check("t4_first", 32'(rd_log[mark]), 32'(b_first[i]));
        end
        start_line(5, 1000, 900, 0, 0, 0);
        run(280);
        check("t4_nowrap_reads", 32'(rd_log.size() - mark), 32'd0);

        // line_start arriving mid-fetch
        oc = ov_cnt;
        start_line(400, 350, 380, 1, 2, 0);
        run(99);
        start_line(400, 350, 380, 1, 2, 0);
        check("t5_p1_vld", 32'(p1_line_vld), 32'd0);
        check("t5_p2_vld", 32'(p2_line_vld), 32'd0);
        run(280);
        check("t5_ov_pulses", 32'(ov_cnt - oc), 32'd1);
        start_line(600, 0, 0, 0, 0, 0);
        check("t5_restart_p1_vld", 32'(p1_line_vld), 32'd1);
        check("t5_restart_p2_vld", 32'(p2_line_vld), 32'd1);
        run(280);

        // asynchronous reset during the p2 fetch
        start_line(400, 350, 380, 1, 2, 0);
        run(200);
        #1;
        rst = 1'b1;
        #1;
        check("t6_async_rom_en", 32'(rom_en), 32'd0);
        check("t6_async_busy", 32'(busy), 32'd0);
        check("t6_async_p1_vld", 32'(p1_line_vld), 32'd0);
        run(3);
        rst = 1'b0;
        mark = rd_log.size();
        run(300);
        check("t6_no_reads", 32'(rd_log.size() - mark), 32'd0);

        // randomized lines, occasionally too short
        for (int n = 0; n < 30; n++) begin
            L  = int'($urandom_range(0, 700));
            y1 = L - int'($urandom_range(0, 150));
            y2 = L - int'($urandom_range(0, 150));
            if ($urandom_range(0, 3) == 0 || y1 < 0) y1 = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 3) == 0 || y2 < 0) y2 = int'($urandom_range(0, 1023));
            gap = ($urandom_range(0, 9) == 0) ? int'($urandom_range(2, 257))
                                              : int'($urandom_range(258, 300));
            start_line(L, y1, y2, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 1)));
            run(gap - 1);
        end
        start_line(0, 900, 900, 0, 0, 0);
        run(300);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got %0d/%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

endmodule
